// File: rtl/clk_rst_seq.sv
// clk_rst_seq: reset sequencer and per-channel clock-enable generator.
// An async active-low reset is synchronised on deassertion and held for HOLD_CYCLES.
// Channel resets are then released one per cycle in index order. Each released channel
// runs a programmable divider that produces a one-cycle ce pulse and a toggling phase bit.
module clk_rst_seq #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned DIVW        = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset_l,
  input  logic                  soft_rst,
  input  logic [NCH*DIVW-1:0]   div_i,
  output logic [NCH-1:0]        ch_rst_n,
  output logic [NCH-1:0]        ce,
  output logic [NCH-1:0]        phase,
  output logic                  running,
  output logic [7:0]            restarts
);

  localparam int unsigned IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned HCW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NCH - 1);
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STAGGER = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rst_sync;

  state_t                 r_state, w_state_nxt;
  logic [HCW-1:0]         r_hcnt, w_hcnt_nxt;
  logic [IDXW-1:0]        r_idx, w_idx_nxt;
  logic [NCH-1:0]         r_ch_rst_n, w_ch_nxt;
  logic                   r_running, w_running_nxt;
  logic [7:0]             r_restarts, w_restarts_nxt;
  logic                   w_soft_acc;

  logic [DIVW-1:0]        r_dcnt [NCH];
  logic [DIVW-1:0]        r_divq [NCH];
  logic [NCH-1:0]         r_phase;
  logic [NCH-1:0]         w_ce;
  logic [NCH-1:0]         w_rel;

  assign w_rst_sync = r_sync[SYNC_STAGES-1];
  // A restart request is honoured only once the stagger sequence has begun.
  assign w_soft_acc = soft_rst && (r_state != ST_HOLD);
  // Channels whose reset rises on the coming edge load their first divide value.
  assign w_rel      = w_ch_nxt & ~r_ch_rst_n;

  // Reset-deassert synchroniser: clears asynchronously, fills with ones per edge.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state    <= ST_HOLD;
      r_hcnt     <= '0;
      r_idx      <= '0;
      r_ch_rst_n <= '0;
      r_running  <= 1'b0;
      r_restarts <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hcnt     <= w_hcnt_nxt;
      r_idx      <= w_idx_nxt;
      r_ch_rst_n <= w_ch_nxt;
      r_running  <= w_running_nxt;
      r_restarts <= w_restarts_nxt;
    end
  end

  // Sequencer next state: an accepted restart overrides any release on the same edge.
  always_comb begin
    w_state_nxt    = r_state;
    w_hcnt_nxt     = r_hcnt;
    w_idx_nxt      = r_idx;
    w_ch_nxt       = r_ch_rst_n;
    w_restarts_nxt = r_restarts;
    if (w_soft_acc) begin
      w_state_nxt = ST_HOLD;
      w_hcnt_nxt  = '0;
      w_idx_nxt   = '0;
      w_ch_nxt    = '0;
      if (r_restarts != 8'hFF) w_restarts_nxt = r_restarts + 8'd1;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (!w_rst_sync) begin
            w_hcnt_nxt = '0;
          end else if (r_hcnt == HOLD_LAST) begin
            w_state_nxt = ST_STAGGER;
            w_hcnt_nxt  = '0;
            w_idx_nxt   = '0;
          end else begin
            w_hcnt_nxt = r_hcnt + HCW'(1);
          end
        end
        ST_STAGGER: begin
          w_ch_nxt = r_ch_rst_n | (NCH'(1) << r_idx);
          if (r_idx == IDX_LAST) w_state_nxt = ST_RUN;
          else                   w_idx_nxt   = r_idx + IDXW'(1);
        end
        ST_RUN: begin
          w_state_nxt = ST_RUN;
        end
        default: begin
          w_state_nxt = ST_HOLD;
        end
      endcase
    end
    w_running_nxt = (w_state_nxt == ST_RUN);
  end

  // Clock enables decode registered divider state only.
  always_comb begin
    w_ce = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      w_ce[c] = r_ch_rst_n[c] && (r_dcnt[c] == r_divq[c]);
    end
  end

  // Per-channel dividers: load on release, count, reload and toggle phase on each ce.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        r_dcnt[c] <= '0;
        r_divq[c] <= '0;
      end
      r_phase <= '0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (w_soft_acc) begin
          r_dcnt[c]  <= '0;
          r_divq[c]  <= '0;
          r_phase[c] <= 1'b0;
        end else if (w_rel[c]) begin
          r_dcnt[c] <= '0;
          r_divq[c] <= div_i[c*DIVW +: DIVW];
        end else if (!r_ch_rst_n[c]) begin
          r_dcnt[c] <= '0;
        end else if (w_ce[c]) begin
          r_dcnt[c]  <= '0;
          r_divq[c]  <= div_i[c*DIVW +: DIVW];
          r_phase[c] <= ~r_phase[c];
        end else begin
          r_dcnt[c] <= r_dcnt[c] + DIVW'(1);
        end
      end
    end
  end

  assign ch_rst_n = r_ch_rst_n;
  assign ce       = w_ce;
  assign phase    = r_phase;
  assign running  = r_running;
  assign restarts = r_restarts;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Testbench for clk_rst_seq: directed timeline checks plus a cycle-by-cycle comparison
// against an edge-count based reference model.
module tb_clk_rst_seq;

  localparam int NCH  = 4;
  localparam int DIVW = 8;
  localparam int SYNC = 2;
  localparam int HOLD = 4;
  localparam int VW   = 3*NCH + 9;

  logic                clk = 1'b0;
  logic                reset_l = 1'b0;
  logic                soft_rst = 1'b0;
  logic [NCH*DIVW-1:0] div_i = '0;
  logic [NCH-1:0]      ch_rst_n, ce, phase;
  logic                running;
  logic [7:0]          restarts;

  int n_tests = 0;
  int n_fail  = 0;

  clk_rst_seq #(.NCH(NCH), .DIVW(DIVW), .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset_l(reset_l), .soft_rst(soft_rst), .div_i(div_i),
    .ch_rst_n(ch_rst_n), .ce(ce), .phase(phase), .running(running), .restarts(restarts)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: edges counted from reset_l rising; channel c is released at
  // edge m_stag+c+1; a period that started at edge s with divide d has its ce in
  // the cycle after edge s+d and the next period starts at edge s+d+1.
  int             m_edge, m_stag, m_restarts;
  logic [NCH-1:0] m_rel, m_phase;
  int             m_start [NCH];
  int             m_div   [NCH];

  task automatic m_reset();
    m_edge = 0; m_stag = SYNC + HOLD; m_restarts = 0;
    m_rel = '0; m_phase = '0;
    for (int c = 0; c < NCH; c++) begin m_start[c] = 0; m_div[c] = 0; end
  endtask

  task automatic m_step(input logic s, input logic [NCH*DIVW-1:0] d);
    int n;
    m_edge++;
    n = m_edge;
    if (s && n > m_stag) begin
      if (m_restarts < 255) m_restarts++;
      m_stag  = n + HOLD;
      m_rel   = '0;
      m_phase = '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (m_rel[c]) begin
          if (n == m_start[c] + m_div[c] + 1) begin
            m_phase[c] = ~m_phase[c];
            m_start[c] = n;
            m_div[c]   = int'(d[c*DIVW +: DIVW]);
          end
        end else if (n == m_stag + c + 1) begin
          m_rel[c]   = 1'b1;
          m_start[c] = n;
          m_div[c]   = int'(d[c*DIVW +: DIVW]);
        end
      end
    end
  endtask

  function automatic logic [VW-1:0] m_vec();
    logic [NCH-1:0] e;
    for (int c = 0; c < NCH; c++) e[c] = m_rel[c] && (m_edge == m_start[c] + m_div[c]);
    return {m_rel, e, m_phase, &m_rel, 8'(m_restarts)};
  endfunction

  // One clock: capture the inputs seen by the edge, advance the model, settle.
  task automatic tick();
    logic s, r;
    logic [NCH*DIVW-1:0] d;
    s = soft_rst; r = reset_l; d = div_i;
    @(posedge clk);
    if (!r) m_reset();
    else    m_step(s, d);
    #1;
  endtask

  task automatic do_reset();
    reset_l = 1'b0; soft_rst = 1'b0;
    tick(); tick();
    reset_l = 1'b1;
  endtask

  task automatic test_reset();
    logic [VW-1:0] got;
    #1;
    got = {ch_rst_n, ce, phase, running, restarts};
    n_tests++;
    if (got !== '0) begin n_fail++; $display("FAIL reset_no_clk: got %h exp 0", got); end
    do_reset();
    got = {ch_rst_n, ce, phase, running, restarts};
    n_tests++;
    if (got !== '0) begin n_fail++; $display("FAIL reset_clocked: got %h exp 0", got); end
  endtask

  task automatic test_release();
    logic [VW-1:0] got;
    logic [NCH-1:0] exp_ch;
    do_reset();
    div_i = {8'd3, 8'd2, 8'd1, 8'd0};
    for (int i = 1; i <= 14; i++) begin
      tick();
      got = {ch_rst_n, ce, phase, running, restarts};
      n_tests++;
      if (got !== m_vec()) begin n_fail++; $display("FAIL release_model@%0d: got %h exp %h", i, got, m_vec()); end
      exp_ch = (i < 7) ? 4'b0000 : (i >= 10) ? 4'b1111 : 4'((1 << (i - 6)) - 1);
      n_tests++;
      if (ch_rst_n !== exp_ch || running !== (i >= 10)) begin
        n_fail++;
        $display("FAIL release_seq@%0d: got ch=%b run=%b exp ch=%b run=%b", i, ch_rst_n, running, exp_ch, i >= 10);
      end
    end
  endtask

  task automatic test_divide();
    logic [VW-1:0] got;
    logic e0, e3, p0;
    do_reset();
    div_i = {8'd0, 8'd1, 8'd3, 8'd2};
    for (int i = 1; i <= 24; i++) begin
      tick();
      got = {ch_rst_n, ce, phase, running, restarts};
      n_tests++;
      if (got !== m_vec()) begin n_fail++; $display("FAIL divide_model@%0d: got %h exp %h", i, got, m_vec()); end
      if (i >= 7) begin
        e0 = (i == 9 || i == 12 || i == 15 || i == 21);
        e3 = (i >= 10);
        p0 = 1'((int'(i >= 10) + int'(i >= 13) + int'(i >= 16) + int'(i >= 22)) % 2);
        n_tests++;
        if (ce[0] !== e0 || ce[3] !== e3 || phase[0] !== p0) begin
          n_fail++;
          $display("FAIL divide_ce@%0d: got ce0=%b ce3=%b ph0=%b exp %b %b %b", i, ce[0], ce[3], phase[0], e0, e3, p0);
        end
      end
      if (i == 13) div_i[7:0] = 8'd5;
    end
  endtask

  task automatic test_soft_reset();
    logic [VW-1:0] got;
    do_reset();
    div_i = {8'd2, 8'd0, 8'd1, 8'd3};
    for (int i = 1; i <= 30; i++) begin
      soft_rst = (i == 20 || i == 22);
      tick();
      got = {ch_rst_n, ce, phase, running, restarts};
      n_tests++;
      if (got !== m_vec()) begin n_fail++; $display("FAIL soft_model@%0d: got %h exp %h", i, got, m_vec()); end
      if (i == 20 || i == 22 || i == 24) begin
        n_tests++;
        if (ch_rst_n !== 4'b0000 || running !== 1'b0 || restarts !== 8'd1) begin
          n_fail++;
          $display("FAIL soft_hold@%0d: got ch=%b run=%b rs=%0d exp ch=0000 run=0 rs=1", i, ch_rst_n, running, restarts);
        end
      end
      if (i == 25 || i == 28) begin
        n_tests++;
        if (ch_rst_n !== ((i == 25) ? 4'b0001 : 4'b1111) || running !== (i == 28)) begin
          n_fail++;
          $display("FAIL soft_rerelease@%0d: got ch=%b run=%b", i, ch_rst_n, running);
        end
      end
    end
    soft_rst = 1'b0;
  endtask

  task automatic test_collision();
    logic [VW-1:0] got;
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      soft_rst = (i == 10);
      tick();
      got = {ch_rst_n, ce, phase, running, restarts};
      n_tests++;
      if (got !== m_vec()) begin n_fail++; $display("FAIL collide_model@%0d: got %h exp %h", i, got, m_vec()); end
      if (i >= 10 && i <= 14) begin
        n_tests++;
        if (running !== 1'b0 || ch_rst_n !== 4'b0000 || restarts !== 8'd1) begin
          n_fail++;
          $display("FAIL collide@%0d: got run=%b ch=%b rs=%0d exp 0 0000 1", i, running, ch_rst_n, restarts);
        end
      end
      if (i == 18) begin
        n_tests++;
        if (running !== 1'b1) begin n_fail++; $display("FAIL collide_rerun: got %b exp 1", running); end
      end
    end
    soft_rst = 1'b0;
  endtask

  task automatic test_async_abort();
    logic [VW-1:0] got;
    do_reset();
    for (int i = 1; i <= 18; i++) begin
      soft_rst = (i == 8);
      tick();
      got = {ch_rst_n, ce, phase, running, restarts};
      n_tests++;
      if (got !== m_vec()) begin n_fail++; $display("FAIL abort_pre@%0d: got %h exp %h", i, got, m_vec()); end
    end
    soft_rst = 1'b0;
    #2 reset_l = 1'b0;
    #1;
    got = {ch_rst_n, ce, phase, running, restarts};
    n_tests++;
    if (got !== '0) begin n_fail++; $display("FAIL abort_async: got %h exp 0", got); end
    tick(); tick();
    reset_l = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      got = {ch_rst_n, ce, phase, running, restarts};
      n_tests++;
      if (got !== m_vec()) begin n_fail++; $display("FAIL abort_replay@%0d: got %h exp %h", i, got, m_vec()); end
      if (i == 7 || i == 10) begin
        n_tests++;
        if (ch_rst_n !== ((i == 7) ? 4'b0001 : 4'b1111) || running !== (i == 10)) begin
          n_fail++;
          $display("FAIL abort_seq@%0d: got ch=%b run=%b", i, ch_rst_n, running);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [VW-1:0] got;
    do_reset();
    soft_rst = 1'b1;
    for (int i = 1; i <= 1600; i++) begin
      tick();
      got = {ch_rst_n, ce, phase, running, restarts};
      n_tests++;
      if (got !== m_vec()) begin n_fail++; $display("FAIL sat_model@%0d: got %h exp %h", i, got, m_vec()); end
    end
    soft_rst = 1'b0;
    tick();
    n_tests++;
    if (restarts !== 8'd255) begin n_fail++; $display("FAIL saturation: got %0d exp 255", restarts); end
  endtask

  task automatic test_random();
    logic [VW-1:0] got;
    int ch, r;
    do_reset();
    for (int c = 0; c < NCH; c++) div_i[c*DIVW +: DIVW] = 8'($urandom_range(0, 6));
    for (int i = 1; i <= 4000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        ch = $urandom_range(0, NCH - 1);
        r  = $urandom_range(0, 9);
        div_i[ch*DIVW +: DIVW] = (r == 9) ? 8'd255 : 8'(r);
      end
      soft_rst = ($urandom_range(0, 199) == 0);
      tick();
      got = {ch_rst_n, ce, phase, running, restarts};
      n_tests++;
      if (got !== m_vec()) begin n_fail++; $display("FAIL random_model@%0d: got %h exp %h", i, got, m_vec()); end
    end
    soft_rst = 1'b0;
  endtask

  initial begin
    m_reset();
    test_reset();
    test_release();
    test_divide();
    test_soft_reset();
    test_collision();
    test_async_abort();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
